uart_csr_arb: RTL and testbench

Round-robin arbiter and sequencer sharing the single UART CSR memory port (addr/wdata/rdata/wen/cs) among NREQ requesters, e.g. host bus bridge and debug master. It accepts one command at a time and drives exactly one single-cycle CSR access per command. It captures read data and returns it to the winning requester with a one-cycle response pulse. It sits directly in front of the UART CSR block, which it feeds with registered signals.

---
 rtl/uart_csr_arb_pkg.sv | 20 ++
 rtl/uart_csr_rr_pick.sv | 50 +++++
 rtl/uart_csr_arb.sv | 130 +++++++++++++
 tb/tb_uart_csr_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_csr_arb_pkg.sv
// Shared types and constants for the UART CSR port arbiter.
package uart_csr_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned NREQ_MIN       = 2;
  localparam int unsigned NREQ_MAX       = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Index width for a requester count; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_csr_rr_pick.sv
// Combinational round-robin picker: rotate so ptr+1 is at bit 0,
// take the lowest set bit, then rotate the result back.
module uart_csr_rr_pick
  import uart_csr_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int unsigned     start;
  logic [NREQ-1:0] rot;
  logic [IW-1:0]   enc;
  logic            found;

  always_comb begin
    start = (32'(ptr) + 32'd1) % NREQ;
    rot   = '0;
    for (int i = 0; i < NREQ; i++) begin
      rot[i] = req[IW'((start + 32'(i)) % NREQ)];
    end
  end

  // Lowest set bit of the rotated vector has the highest priority.
  always_comb begin
    enc   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        enc   = IW'(i);
      end
    end
  end

  always_comb begin
    any   = |req;
    idx   = IW'((32'(enc) + start) % NREQ);
    grant = '0;
    if (any) begin
      grant = NREQ'(1) << idx;
    end
  end

endmodule

// File: rtl/uart_csr_arb.sv
// Round-robin arbiter and sequencer driving one registered CSR access per
// accepted command and returning read data with a one-cycle response pulse.
module uart_csr_arb
  import uart_csr_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_wen,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ready,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]      rsp_rdata,
  output logic                       csr_cs,
  output logic                       csr_wen,
  output logic [ADDR_WIDTH-1:0]      csr_addr,
  output logic [DATA_WIDTH-1:0]      csr_wdata,
  input  logic [DATA_WIDTH-1:0]      csr_rdata
);

  localparam int unsigned IW = idx_width(NREQ);

  state_t                state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         lat_idx_q, lat_idx_d;
  logic                  cs_d, wen_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [NREQ-1:0]       rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  logic [NREQ-1:0]       pick_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_any;
  logic                  sel_wen;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  uart_csr_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Payload of the current round-robin winner.
  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        sel_wen   = req_wen[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lat_idx_d   = lat_idx_q;
    cs_d        = 1'b0;
    wen_d       = 1'b0;
    addr_d      = csr_addr;
    wdata_d     = csr_wdata;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata;
    req_ready   = '0;

    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (pick_any) begin
          req_ready = pick_grant;
          lat_idx_d = pick_idx;
          cs_d      = 1'b1;
          wen_d     = sel_wen;
          addr_d    = sel_addr;
          wdata_d   = sel_wdata;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        // csr_wen still holds the latched command direction here.
        rsp_valid_d = NREQ'(1) << lat_idx_q;
        rsp_rdata_d = csr_wen ? '0 : csr_rdata;
        ptr_d       = lat_idx_q;
        state_d     = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(NREQ - 1);
      lat_idx_q <= '0;
      csr_cs    <= 1'b0;
      csr_wen   <= 1'b0;
      csr_addr  <= '0;
      csr_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lat_idx_q <= lat_idx_d;
      csr_cs    <= cs_d;
      csr_wen   <= wen_d;
      csr_addr  <= addr_d;
      csr_wdata <= wdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_csr_arb.sv
// Self-checking bench for uart_csr_arb with three requesters and a small
// CSR register model.
module tb_uart_csr_arb;
  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;

  logic              clk;
  logic              rstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_wen;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              csr_cs;
  logic              csr_wen;
  logic [AW-1:0]     csr_addr;
  logic [DW-1:0]     csr_wdata;
  logic [DW-1:0]     csr_rdata;

  uart_csr_arb #(.NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .csr_cs    (csr_cs),
    .csr_wen   (csr_wen),
    .csr_addr  (csr_addr),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR register file model: 16 words, preset to 0x1000_0000 + index.
  logic          mem_init_n;
  logic [DW-1:0] mem [16];
  always @(posedge clk or negedge mem_init_n) begin
    if (!mem_init_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (csr_cs && csr_wen) begin
      mem[csr_addr[3:0]] <= csr_wdata;
    end
  end
  assign csr_rdata = mem[csr_addr[3:0]];

  int n_chk;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] w,
                       input logic [15:0] a, input logic [31:0] d);
    req_valid = v;
    req_wen   = w;
    req_addr  = {3{a}};
    req_wdata = {3{d}};
  endtask

  task automatic do_reset();
    drive(3'b000, 3'b000, 16'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [2:0]  e_ready;
    logic        e_cs;
    logic        e_cwen;
    logic [15:0] e_caddr;
    logic [2:0]  e_rsp;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants, cs_cnt, r0_cnt, r1_cnt, acc, g, max_wait;
    int last [3];
    n_chk = 0;
    n_err = 0;
    rstn = 1'b0;
    mem_init_n = 1'b0;
    drive(3'b000, 3'b000, 16'h0, 32'h0);

    // write 0xA to REG1, read it back, then a two-way contention pair
    tbl[0]  = '{3'b001, 3'b001, 16'h1, 32'hA, 3'b001, 1'b0, 1'b0, 16'h0, 3'b000, 32'h0};
    tbl[1]  = '{3'b000, 3'b000, 16'h0, 32'h0, 3'b000, 1'b1, 1'b1, 16'h1, 3'b000, 32'h0};
    tbl[2]  = '{3'b001, 3'b000, 16'h1, 32'h0, 3'b001, 1'b0, 1'b0, 16'h1, 3'b001, 32'h0};
    tbl[3]  = '{3'b000, 3'b000, 16'h0, 32'h0, 3'b000, 1'b1, 1'b0, 16'h1, 3'b000, 32'h0};
    tbl[4]  = '{3'b000, 3'b000, 16'h0, 32'h0, 3'b000, 1'b0, 1'b0, 16'h1, 3'b001, 32'hA};
    tbl[5]  = '{3'b011, 3'b000, 16'h2, 32'h0, 3'b010, 1'b0, 1'b0, 16'h1, 3'b000, 32'hA};
    tbl[6]  = '{3'b001, 3'b000, 16'h2, 32'h0, 3'b000, 1'b1, 1'b0, 16'h2, 3'b000, 32'hA};
    tbl[7]  = '{3'b001, 3'b000, 16'h2, 32'h0, 3'b001, 1'b0, 1'b0, 16'h2, 3'b010, 32'h1000_0002};
    tbl[8]  = '{3'b000, 3'b000, 16'h0, 32'h0, 3'b000, 1'b1, 1'b0, 16'h2, 3'b000, 32'h1000_0002};
    tbl[9]  = '{3'b000, 3'b000, 16'h0, 32'h0, 3'b000, 1'b0, 1'b0, 16'h2, 3'b001, 32'h1000_0002};
    tbl[10] = '{3'b000, 3'b000, 16'h0, 32'h0, 3'b000, 1'b0, 1'b0, 16'h2, 3'b000, 32'h1000_0002};

    #12;
    rstn = 1'b1;
    mem_init_n = 1'b1;
    chk("reset_cs", 32'(csr_cs), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_csr_addr", 32'(csr_addr), 32'd0);
    tick();

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].valid, tbl[i].wen, tbl[i].addr, tbl[i].wdata);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d_cs", i), 32'(csr_cs), 32'(tbl[i].e_cs));
      chk($sformatf("v%0d_cwen", i), 32'(csr_wen), 32'(tbl[i].e_cwen));
      chk($sformatf("v%0d_caddr", i), 32'(csr_addr), 32'(tbl[i].e_caddr));
      chk($sformatf("v%0d_rsp", i), 32'(rsp_valid), 32'(tbl[i].e_rsp));
      chk($sformatf("v%0d_rdata", i), rsp_rdata, tbl[i].e_rdata);
      tick();
    end
    chk("mem_reg1", mem[1], 32'hA);

    // simultaneous requests right after reset
    do_reset();
    drive(3'b011, 3'b000, 16'h3, 32'h0);
    #1;
    chk("sim_ready0", 32'(req_ready), 32'b001);
    tick();
    drive(3'b010, 3'b000, 16'h3, 32'h0);
    #1;
    chk("sim_access0", 32'(csr_cs), 32'd1);
    tick();
    chk("sim_ready1", 32'(req_ready), 32'b010);
    chk("sim_rsp0", 32'(rsp_valid), 32'b001);
    tick();
    drive(3'b000, 3'b000, 16'h0, 32'h0);
    chk("sim_access1", 32'(csr_cs), 32'd1);
    tick();
    chk("sim_rsp1", 32'(rsp_valid), 32'b010);
    chk("sim_rdata1", rsp_rdata, 32'h1000_0003);
    tick();

    // fairness with all three requesters held active
    do_reset();
    drive(3'b111, 3'b000, 16'h4, 32'h0);
    grants = 0;
    max_wait = 0;
    for (int r = 0; r < 3; r++) last[r] = -1;
    for (int cyc = 0; cyc < 60 && grants < 12; cyc++) begin
      #1;
      if (req_ready != 3'b000) begin
        g = -1;
        for (int r = 0; r < 3; r++) if (req_ready[r]) g = r;
        chk($sformatf("fair_grant%0d", grants), 32'(g), 32'(grants % 3));
        if (grants - last[g] - 1 > max_wait) max_wait = grants - last[g] - 1;
        last[g] = grants;
        grants++;
      end
      tick();
    end
    drive(3'b000, 3'b000, 16'h0, 32'h0);
    chk("fair_count", 32'(grants), 32'd12);
    chk("fair_max_wait_le2", 32'(max_wait <= 2), 32'd1);
    repeat (3) tick();

    // back-to-back reads from requester 1 alone
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      drive((acc < 4) ? 3'b010 : 3'b000, 3'b000, 16'h6, 32'h0);
      #1;
      chk($sformatf("b2b_cs%0d", k), 32'(csr_cs), 32'((k % 2 == 1) && (k <= 7)));
      chk($sformatf("b2b_rsp%0d", k), 32'(rsp_valid[1]), 32'((k % 2 == 0) && (k >= 2) && (k <= 8)));
      if (req_ready[1]) acc++;
      tick();
    end
    chk("b2b_accepts", 32'(acc), 32'd4);

    // reset while the write access is on the CSR port
    do_reset();
    drive(3'b001, 3'b001, 16'h5, 32'h55);
    #1;
    chk("rst_ready", 32'(req_ready), 32'b001);
    tick();
    drive(3'b000, 3'b000, 16'h0, 32'h0);
    chk("rst_cs_before", 32'(csr_cs), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_cs_now", 32'(csr_cs), 32'd0);
    chk("rst_cwen_now", 32'(csr_wen), 32'd0);
    chk("rst_rsp_now", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    r0_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rsp_valid != 3'b000 || csr_cs) r0_cnt++;
    end
    chk("rst_no_activity", 32'(r0_cnt), 32'd0);
    chk("rst_no_write", mem[5], 32'h1000_0005);
    drive(3'b111, 3'b000, 16'h0, 32'h0);
    #1;
    chk("rst_first_winner", 32'(req_ready), 32'b001);
    drive(3'b000, 3'b000, 16'h0, 32'h0);
    tick();

    // requester 1 withdraws while requester 0 is served
    drive(3'b011, 3'b000, 16'h3, 32'h0);
    #1;
    chk("wd_ready", 32'(req_ready), 32'b001);
    tick();
    drive(3'b000, 3'b000, 16'h0, 32'h0);
    cs_cnt = 0;
    r0_cnt = 0;
    r1_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (csr_cs) cs_cnt++;
      if (rsp_valid[0]) r0_cnt++;
      if (rsp_valid[1]) r1_cnt++;
      tick();
    end
    chk("wd_cs_count", 32'(cs_cnt), 32'd1);
    chk("wd_rsp0_count", 32'(r0_cnt), 32'd1);
    chk("wd_rsp1_count", 32'(r1_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
